// File: rtl/quiz_buzzer_pkg.sv
// Shared types and helpers for the quiz buzzer arbiter.
package quiz_buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam int DEF_SCAN_DIV  = 1000;
    localparam int DEF_DEB_LEN   = 4;
    localparam int DEF_ANS_TICKS = 50000;
    localparam int MAX_CH        = 16;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] lowest_set(input logic [MAX_CH-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/quiz_buzzer_arbiter_debounce.sv
// Button conditioner: 2-FF synchroniser, tick-sampled debounce, rising-edge strobe.
module buzz_debounce
    import quiz_buzzer_pkg::*;
#(
    parameter int DEB_LEN = DEF_DEB_LEN
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic               sync_q1;
    logic               sync_q2;
    logic               level_d;
    logic [DEB_LEN-1:0] samp;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            samp    <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (tick) samp <= DEB_LEN'({samp, sync_q2});
            if (&samp && !level) begin
                level <= 1'b1;
            end else if (~|samp && level) begin
                level <= 1'b0;
            end
            level_d <= level;
            // Strobe lands one cycle after the accepted 0->1 transition.
            rise    <= level & ~level_d;
        end
    end

endmodule

// File: rtl/quiz_buzzer_arbiter.sv
// N-channel quiz buzzer arbiter: scan divider, conditioned inputs, round FSM.
//   state   | meaning
//   IDLE    | no round; presses are recorded as fouls
//   ARMED   | round open; first non-fouled press wins
//   LOCKED  | winner latched; answer timer counting down per tick
//   TIMEOUT | answer window expired; winner held until arm or clear
module quiz_buzzer_arbiter
    import quiz_buzzer_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int SCAN_DIV  = DEF_SCAN_DIV,
    parameter int DEB_LEN   = DEF_DEB_LEN,
    parameter int ANS_TICKS = DEF_ANS_TICKS,
    parameter int IDW       = $clog2(N_CH),
    parameter int TW        = $clog2(ANS_TICKS + 1)
) (
    input  logic            clk_50M,
    input  logic            rst_n,
    input  logic            host_arm,
    input  logic            host_clear,
    input  logic [N_CH-1:0] buzz_in,
    output logic [1:0]      state,
    output logic            winner_valid,
    output logic [IDW-1:0]  winner_id,
    output logic [N_CH-1:0] winner_onehot,
    output logic [N_CH-1:0] foul,
    output logic [TW-1:0]   time_left,
    output logic            timeout_pulse
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0]   scan_cnt;
    logic            tick;
    logic            arm_rise, clear_rise, arm_level, clear_level;
    logic [N_CH-1:0] buzz_rise, buzz_level;
    logic            unused_levels;

    assign tick = (scan_cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)    scan_cnt <= '0;
        else if (tick) scan_cnt <= '0;
        else           scan_cnt <= scan_cnt + CW'(1);
    end

    buzz_debounce #(.DEB_LEN(DEB_LEN)) u_deb_arm (
        .clk_50M(clk_50M), .rst_n(rst_n), .tick(tick),
        .raw(host_arm), .level(arm_level), .rise(arm_rise)
    );

    buzz_debounce #(.DEB_LEN(DEB_LEN)) u_deb_clear (
        .clk_50M(clk_50M), .rst_n(rst_n), .tick(tick),
        .raw(host_clear), .level(clear_level), .rise(clear_rise)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_buzz
        buzz_debounce #(.DEB_LEN(DEB_LEN)) u_deb_buzz (
            .clk_50M(clk_50M), .rst_n(rst_n), .tick(tick),
            .raw(buzz_in[g]), .level(buzz_level[g]), .rise(buzz_rise[g])
        );
    end

    assign unused_levels = ^{arm_level, clear_level, buzz_level};

    state_t          state_q, state_d;
    logic [N_CH-1:0] foul_q, foul_d, oh_q, oh_d, elig;
    logic [IDW-1:0]  id_q, id_d, elig_id;
    logic [TW-1:0]   tl_q, tl_d;
    logic            to_q, to_d;

    assign elig    = buzz_rise & ~foul_q;
    assign elig_id = IDW'(lowest_set(MAX_CH'(elig)));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            foul_q  <= '0;
            oh_q    <= '0;
            id_q    <= '0;
            tl_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            foul_q  <= foul_d;
            oh_q    <= oh_d;
            id_q    <= id_d;
            tl_q    <= tl_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        foul_d  = foul_q;
        oh_d    = oh_q;
        id_d    = id_q;
        tl_d    = tl_q;
        to_d    = 1'b0;
        if (clear_rise) begin
            state_d = IDLE;
            foul_d  = '0;
            oh_d    = '0;
            id_d    = '0;
            tl_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A press on the same cycle as arm is still a foul.
                    foul_d = foul_q | buzz_rise;
                    if (arm_rise) state_d = ARMED;
                end
                ARMED: begin
                    if (|elig) begin
                        state_d = LOCKED;
                        id_d    = elig_id;
                        oh_d    = N_CH'(1) << elig_id;
                        tl_d    = TW'(ANS_TICKS);
                    end
                end
                LOCKED: begin
                    if (tick) begin
                        if (tl_q <= TW'(1)) begin
                            state_d = TIMEOUT;
                            tl_d    = '0;
                            to_d    = 1'b1;
                        end else begin
                            tl_d = tl_q - TW'(1);
                        end
                    end
                end
                TIMEOUT: begin
                    if (arm_rise) begin
                        state_d = ARMED;
                        oh_d    = '0;
                        id_d    = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign state         = state_q;
    assign winner_valid  = (state_q == LOCKED) || (state_q == TIMEOUT);
    assign winner_id     = id_q;
    assign winner_onehot = oh_q;
    assign foul          = foul_q;
    assign time_left     = tl_q;
    assign timeout_pulse = to_q;

endmodule

// File: tb/tb_quiz_buzzer_arbiter.sv
// Directed self-checking bench for quiz_buzzer_arbiter (4 ch, fast scan).
module tb_quiz_buzzer_arbiter;

    localparam int N_CH      = 4;
    localparam int SCAN_DIV  = 4;
    localparam int DEB_LEN   = 3;
    localparam int ANS_TICKS = 5;

    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_LOCKED = 2'd2, S_TIMEOUT = 2'd3;

    logic       clk_50M = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_arm = 1'b0;
    logic       host_clear = 1'b0;
    logic [3:0] buzz_in = 4'b0000;
    logic [1:0] state;
    logic       winner_valid;
    logic [1:0] winner_id;
    logic [3:0] winner_onehot;
    logic [3:0] foul;
    logic [2:0] time_left;
    logic       timeout_pulse;

    int checks = 0;
    int errors = 0;
    int pulses;
    logic [1:0] ph;

    always #5 clk_50M = ~clk_50M;

    // Mirrors the scan phase so the toggle pattern can be placed against the sample points.
    always @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) ph <= 2'd0;
        else        ph <= ph + 2'd1;
    end

    quiz_buzzer_arbiter #(
        .N_CH(N_CH), .SCAN_DIV(SCAN_DIV), .DEB_LEN(DEB_LEN), .ANS_TICKS(ANS_TICKS)
    ) dut (
        .clk_50M(clk_50M),
        .rst_n(rst_n),
        .host_arm(host_arm),
        .host_clear(host_clear),
        .buzz_in(buzz_in),
        .state(state),
        .winner_valid(winner_valid),
        .winner_id(winner_id),
        .winner_onehot(winner_onehot),
        .foul(foul),
        .time_left(time_left),
        .timeout_pulse(timeout_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_50M);
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== target && n < budget) begin
            @(negedge clk_50M);
            n++;
        end
        chk(tag, 32'(state), 32'(target));
    endtask

    task automatic pulse_arm();
        host_arm = 1'b1;
        cycles(20);
        host_arm = 1'b0;
        cycles(20);
    endtask

    task automatic pulse_clear();
        host_clear = 1'b1;
        cycles(20);
        host_clear = 1'b0;
        cycles(20);
    endtask

    initial begin
        cycles(3);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_valid", 32'(winner_valid), 32'd0);
        chk("rst_onehot", 32'(winner_onehot), 32'd0);
        chk("rst_foul", 32'(foul), 32'd0);
        chk("rst_time", 32'(time_left), 32'd0);
        chk("rst_pulse", 32'(timeout_pulse), 32'd0);
        rst_n = 1'b1;

        // Single press wins, then the answer window expires.
        pulse_arm();
        chk("arm_state", 32'(state), 32'(S_ARMED));
        buzz_in = 4'b0100;
        wait_state(S_LOCKED, 30, "win2_state");
        chk("win2_id", 32'(winner_id), 32'd2);
        chk("win2_onehot", 32'(winner_onehot), 32'b0100);
        chk("win2_valid", 32'(winner_valid), 32'd1);
        chk("win2_time", 32'(time_left), 32'd5);
        buzz_in = 4'b0000;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_50M);
            if (timeout_pulse) pulses++;
        end
        chk("to_pulses", 32'(pulses), 32'd1);
        chk("to_state", 32'(state), 32'(S_TIMEOUT));
        chk("to_id_held", 32'(winner_id), 32'd2);
        chk("to_valid", 32'(winner_valid), 32'd1);
        chk("to_time", 32'(time_left), 32'd0);
        pulse_arm();
        chk("rearm_state", 32'(state), 32'(S_ARMED));
        chk("rearm_valid", 32'(winner_valid), 32'd0);
        chk("rearm_onehot", 32'(winner_onehot), 32'd0);

        // Simultaneous presses: lowest index wins, later presses ignored.
        buzz_in = 4'b1010;
        wait_state(S_LOCKED, 30, "tie_state");
        chk("tie_id", 32'(winner_id), 32'd1);
        chk("tie_onehot", 32'(winner_onehot), 32'b0010);
        buzz_in = 4'b0000;
        cycles(20);
        buzz_in = 4'b1000;
        cycles(20);
        chk("late_id", 32'(winner_id), 32'd1);
        chk("late_onehot", 32'(winner_onehot), 32'b0010);
        buzz_in = 4'b0000;
        cycles(20);
        pulse_clear();
        chk("clr1_state", 32'(state), 32'(S_IDLE));
        chk("clr1_valid", 32'(winner_valid), 32'd0);
        chk("clr1_time", 32'(time_left), 32'd0);

        // Early press fouls ch0; ch0 stays locked out in the armed round.
        buzz_in = 4'b0001;
        cycles(20);
        buzz_in = 4'b0000;
        cycles(20);
        chk("foul0", 32'(foul), 32'b0001);
        chk("foul0_state", 32'(state), 32'(S_IDLE));
        pulse_arm();
        chk("foul_arm_state", 32'(state), 32'(S_ARMED));
        chk("foul_kept", 32'(foul), 32'b0001);
        buzz_in = 4'b0001;
        cycles(20);
        chk("fouled_press", 32'(state), 32'(S_ARMED));
        buzz_in = 4'b0000;
        cycles(20);
        buzz_in = 4'b1000;
        wait_state(S_LOCKED, 30, "win3_state");
        chk("win3_id", 32'(winner_id), 32'd3);
        chk("win3_foul", 32'(foul), 32'b0001);
        buzz_in = 4'b0000;
        pulse_clear();
        chk("clr2_foul", 32'(foul), 32'd0);
        chk("clr2_state", 32'(state), 32'(S_IDLE));
        chk("clr2_onehot", 32'(winner_onehot), 32'd0);

        // Fast toggling and a one-tick glitch never produce a win.
        pulse_arm();
        for (int i = 0; i < 40; i++) begin
            buzz_in[1] = ph[1];
            @(negedge clk_50M);
        end
        buzz_in = 4'b0000;
        cycles(20);
        chk("toggle_state", 32'(state), 32'(S_ARMED));
        buzz_in = 4'b0010;
        cycles(4);
        buzz_in = 4'b0000;
        cycles(20);
        chk("glitch_state", 32'(state), 32'(S_ARMED));
        chk("glitch_valid", 32'(winner_valid), 32'd0);

        // Reset mid-window with ch2 still held.
        buzz_in = 4'b0100;
        wait_state(S_LOCKED, 30, "win_pre_rst");
        cycles(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'(S_IDLE));
        chk("arst_valid", 32'(winner_valid), 32'd0);
        chk("arst_id", 32'(winner_id), 32'd0);
        chk("arst_onehot", 32'(winner_onehot), 32'd0);
        chk("arst_time", 32'(time_left), 32'd0);
        @(negedge clk_50M);
        rst_n = 1'b1;
        cycles(25);
        chk("held_foul", 32'(foul), 32'b0100);
        chk("held_state", 32'(state), 32'(S_IDLE));
        chk("held_valid", 32'(winner_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quiz_buzzer_arbiter.md
Name: quiz_buzzer_arbiter

Overview:
- Parametrised N-channel quiz buzzer (抢答器) controller for the Arty-Z7 design. It runs in the clk_50M domain generated by the board PLL.
- Each contestant input and both host buttons are synchronised, debounced and edge-detected.
- Contestants may buzz only after the host arms a round. The first valid buzz wins and locks out the others; lowest index wins a tie.
- Pressing before the round is armed is flagged as a foul. A bounded answer timer runs after a win.

Parameters:
- N_CH, 4, number of contestant channels, 2..16.
- SCAN_DIV, 1000, clk_50M cycles per scan tick (1000 = 20 us).
- DEB_LEN, 4, number of consecutive equal scan samples required to accept a new level.
- ANS_TICKS, 50000, answer window in scan ticks (50000 = 1 s), at least 1.
- IDW, $clog2(N_CH), width of winner_id (derived).
- TW, $clog2(ANS_TICKS+1), width of time_left (derived).

Ports:
- clk_50M, in, 1, system clock 50 MHz.
- rst_n, in, 1, reset, asynchronous, active-low.
- host_arm, in, 1, raw host button; a rising edge arms a round.
- host_clear, in, 1, raw host button; a rising edge clears the round and all fouls.
- buzz_in, in, N_CH, raw contestant buttons, active-high.
- state, out, 2, current FSM state code.
- winner_valid, out, 1, high in LOCKED and in TIMEOUT.
- winner_id, out, IDW, index of the winning channel.
- winner_onehot, out, N_CH, LED drive; the winner bit is high.
- foul, out, N_CH, sticky per-channel early-press flags.
- time_left, out, TW, remaining answer ticks.
- timeout_pulse, out, 1, one-cycle strobe when the answer window expires.

Behaviour:
- Reset values: all outputs 0, state=IDLE, scan counter 0, debouncers report stable level 0 with no edge pending.
- Scan divider: counter runs 0..SCAN_DIV-1 and wraps. tick is high for one cycle when the counter equals SCAN_DIV-1.
- Input path per button:
  - 2-FF synchroniser.
  - On each tick, sample into a DEB_LEN shift register.
  - Stable level updates only when all DEB_LEN samples are equal and differ from the current level.
  - rise strobe is one cycle, raised the cycle after the stable level goes 0->1.
  - No edge is produced on a release.
- Input latency: press held stable -> rise strobe within (DEB_LEN+1)*SCAN_DIV+3 cycles. Glitches shorter than DEB_LEN-1 ticks produce no edge.
- FSM states: IDLE=0, ARMED=1, LOCKED=2, TIMEOUT=3. In every state, clear_rise -> IDLE, zero all fouls, zero winner outputs and time_left. clear_rise takes priority over every other event in the same cycle.
- IDLE:
  - buzz_rise[i] sets foul[i].
  - arm_rise -> ARMED. Fouls persist.
- ARMED:
  - elig = buzz_rise & ~foul.
  - If elig is non-zero -> LOCKED. Winner = lowest set index of elig. Set winner_id, winner_onehot, winner_valid. time_left = ANS_TICKS.
  - arm_rise in ARMED is ignored.
  - If all channels are fouled, the FSM stays ARMED until clear.
- LOCKED:
  - Each tick decrements time_left.
  - A tick while time_left==1 -> TIMEOUT, time_left=0, timeout_pulse high for that cycle.
  - Buzzes and arm_rise are ignored.
- TIMEOUT:
  - Winner outputs held.
  - arm_rise -> ARMED with winner outputs cleared and fouls kept.
  - Buzzes are ignored.
- Simultaneous events:
  - Buzzes on the same cycle: lowest index wins.
  - Buzz and arm on the same IDLE cycle: the foul is recorded, then the FSM arms.
- Reset mid-round: all state discarded immediately and asynchronously. Debouncers restart from level 0, so a button held through reset produces a rise edge after DEB_LEN ticks.

Decomposition:
- Package quiz_buzzer_pkg holds:
  - the state enum (IDLE/ARMED/LOCKED/TIMEOUT, 2-bit);
  - the lowest-set-bit priority encoder function;
  - default constants for SCAN_DIV, DEB_LEN, ANS_TICKS.
- Sub-module buzz_debounce (ports clk_50M, rst_n, tick, raw, level, rise; parameter DEB_LEN) contains the synchroniser, the sample shift register and the edge detector.
- buzz_debounce is instantiated N_CH+2 times. The scan divider and the FSM stay in the top level.

Test Plan (N_CH=4, SCAN_DIV=4, DEB_LEN=3, ANS_TICKS=5):
- Reset, then arm, then buzz_in=4'b0100 held 20 cycles -> state=LOCKED, winner_id=2, winner_onehot=4'b0100, time_left=5.
- Armed round, buzz_in=4'b1010 asserted on the same cycle -> winner_id=1; a later press of ch3 changes nothing.
- IDLE, pulse ch0 -> foul=4'b0001. Then arm, then press ch0 then ch3 -> winner_id=3, foul still 4'b0001. Then clear -> foul=0, state=IDLE.
- LOCKED, wait 5 ticks -> exactly one timeout_pulse, state=TIMEOUT, winner held. Then arm -> state=ARMED, winner_valid=0.
- Armed round, toggle buzz_in[1] every 2 cycles for 40 cycles -> no win, state stays ARMED.
- LOCKED, assert rst_n=0 mid-window -> all outputs 0 the same cycle. Release with ch2 still held -> the FSM is IDLE, so once the debouncer accepts the held level foul=4'b0100.
